// File: rtl/vga_frame_capture.sv
// VGA sink: recovers row/col from sync edges, checks timing and
// downsamples locked frames into 32x32-cell, 3-bit capture-RAM writes.
//
// Ports:
//   Clock, Reset        one pixel per clock; sync active-high reset
//   iHSync, iVSync      syncs from the VGA controller
//   iRed/iGreen/iBlue   pixel bits
//   oWriteEnable        capture-RAM write strobe (one cycle)
//   oWriteAddress       {row[8:4], col[9:5]}
//   oDataOut            {R,G,B} of the cell-centre pixel
//   oLocked             timing lock achieved
//   oFrameDone          pulse at the end of each captured frame
//   oSyncError          pulse on any timing violation
//   oFrameCount         captured frames, wraps

module vga_frame_capture #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iHSync,
    input  logic       iVSync,
    input  logic       iRed,
    input  logic       iGreen,
    input  logic       iBlue,
    output logic       oWriteEnable,
    output logic [9:0] oWriteAddress,
    output logic [2:0] oDataOut,
    output logic       oLocked,
    output logic       oFrameDone,
    output logic       oSyncError,
    output logic [7:0] oFrameCount
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_LAST  = 10'(H_SYNC - 1);
    localparam logic [9:0] H_START  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END    = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_START  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END    = 10'(V_SYNC + V_BACK + V_VISIBLE);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t     state_q, state_d;

    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;
    logic       hs2_q, hs2_d;
    logic       vs2_q, vs2_d;
    logic [2:0] rgb1_q, rgb1_d;

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    logic       we_q, we_d;
    logic [9:0] addr_q, addr_d;
    logic [2:0] data_q, data_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] fcnt_q, fcnt_d;

    logic       h_edge;
    logic       h_end;
    logic       v_edge;
    logic       bad;
    logic       err;
    logic       cap;
    logic [9:0] col;
    logic [8:0] row;

    always_comb begin
        hs1_d  = iHSync;
        vs1_d  = iVSync;
        rgb1_d = {iRed, iGreen, iBlue};
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;

        h_edge = (hs1_q == SYNC_ACTIVE) && (hs2_q != SYNC_ACTIVE);
        h_end  = (hs1_q != SYNC_ACTIVE) && (hs2_q == SYNC_ACTIVE);
        v_edge = (vs1_q == SYNC_ACTIVE) && (vs2_q != SYNC_ACTIVE);

        // hcnt_d/vcnt_d are the position of the stage-1 pixel;
        // hcnt_q/vcnt_q therefore describe the pixel before it.
        hcnt_d = h_edge ? 10'd0 : hcnt_q + 10'd1;
        if (v_edge) begin
            vcnt_d = 10'd0;
        end else if (h_edge) begin
            vcnt_d = vcnt_q + 10'd1;
        end else begin
            vcnt_d = vcnt_q;
        end

        col = hcnt_d - H_START;
        row = 9'(vcnt_d - V_START);

        cap = (hcnt_d >= H_START) && (hcnt_d < H_END)
           && (vcnt_d >= V_START) && (vcnt_d < V_END)
           && (col[4:0] == 5'd16) && (row[3:0] == 4'd8);

        // Period: previous pixel closed the line at H_TOTAL-1.
        // Width: first inactive pixel sits at position H_SYNC.
        bad = (h_edge && (hcnt_q != H_LAST))
           || (h_end  && (hcnt_q != HS_LAST))
           || (v_edge && (vcnt_q != V_LAST));
        err = (state_q != SEARCH) && bad;

        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err;
        fcnt_d  = fcnt_q;

        unique case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (err) begin
                    state_d = SEARCH;
                end else if (v_edge) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (err) begin
                    state_d = SEARCH;
                end else begin
                    if (v_edge) begin
                        done_d = 1'b1;
                        fcnt_d = fcnt_q + 8'd1;
                    end
                    if (cap) begin
                        we_d   = 1'b1;
                        addr_d = {row[8:4], col[9:5]};
                        data_d = rgb1_q;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            // Syncs reset to the asserted level so a line already
            // in progress cannot look like a fresh sync edge.
            hs1_q   <= SYNC_ACTIVE;
            vs1_q   <= SYNC_ACTIVE;
            hs2_q   <= SYNC_ACTIVE;
            vs2_q   <= SYNC_ACTIVE;
            rgb1_q  <= 3'd0;
            hcnt_q  <= 10'd0;
            vcnt_q  <= 10'd0;
            state_q <= SEARCH;
            we_q    <= 1'b0;
            addr_q  <= 10'd0;
            data_q  <= 3'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= 8'd0;
        end else begin
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            rgb1_q  <= rgb1_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign oWriteEnable  = we_q;
    assign oWriteAddress = addr_q;
    assign oDataOut      = data_q;
    assign oLocked       = (state_q == LOCKED);
    assign oFrameDone    = done_q;
    assign oSyncError    = err_q;
    assign oFrameCount   = fcnt_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture: a reduced-size main instance for lock,
// capture and error cases, and a tiny instance for frame-count wrap.

module tb_vga_frame_capture;

    localparam bit SA = 1'b0;

    logic Clock = 1'b0;
    logic Reset;
    logic iHSync, iVSync, iRed, iGreen, iBlue;

    logic       a_we, a_lock, a_done, a_err;
    logic [9:0] a_addr;
    logic [2:0] a_data;
    logic [7:0] a_fc;

    logic       b_we, b_lock, b_done, b_err;
    logic [9:0] b_addr;
    logic [2:0] b_data;
    logic [7:0] b_fc;

    always #5 Clock = ~Clock;

    vga_frame_capture #(
        .H_VISIBLE(96), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(32), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(SA)
    ) dut_a (
        .Clock(Clock), .Reset(Reset),
        .iHSync(iHSync), .iVSync(iVSync),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oWriteEnable(a_we), .oWriteAddress(a_addr),
        .oDataOut(a_data), .oLocked(a_lock),
        .oFrameDone(a_done), .oSyncError(a_err),
        .oFrameCount(a_fc)
    );

    vga_frame_capture #(
        .H_VISIBLE(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE(SA)
    ) dut_b (
        .Clock(Clock), .Reset(Reset),
        .iHSync(iHSync), .iVSync(iVSync),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oWriteEnable(b_we), .oWriteAddress(b_addr),
        .oDataOut(b_data), .oLocked(b_lock),
        .oFrameDone(b_done), .oSyncError(b_err),
        .oFrameCount(b_fc)
    );

    // kind: 0 clean, 1 short line, 2 narrow hsync, 3 reset mid-line
    typedef struct {
        int kind;
        int at;
        int nl;
        int pat;
        int wr;
        int e_err;
        int e_done;
        int e_wr;
        int e_lock;
        int e_fc;
    } vec_t;

    typedef struct {
        int c;
        int addr;
        int data;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hvis, hfr, hsy, hbk, vvis, vfr, vsy, vbk;
    bit mon_a = 1'b0;
    int a_nwr = 0, a_ndone = 0, a_nerr = 0;
    int b_nwr = 0, b_ndone = 0, b_nerr = 0;
    wr_t q[$];
    wr_t wexp;
    vec_t vecs[18];

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got,
                         input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (mon_a) begin
            if (a_we) begin
                a_nwr++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0d, required none",
                             a_addr, a_data);
                end else begin
                    wexp = q.pop_front();
                    if (int'(a_addr) != wexp.addr ||
                        int'(a_data) != wexp.data ||
                        cyc - wexp.c != 2) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%0d lat=%0d, required addr=%0d data=%0d lat=2",
                                 a_addr, a_data, cyc - wexp.c,
                                 wexp.addr, wexp.data);
                    end
                end
            end
            if (a_done) a_ndone++;
            if (a_err)  a_nerr++;
        end
        if (b_we)   b_nwr++;
        if (b_done) b_ndone++;
        if (b_err)  b_nerr++;
    end

    task automatic send_frame(input vec_t v);
        int ht, len, w, cut, col, row, pix;
        wr_t it;
        ht  = hsy + hbk + hvis + hfr;
        cut = (v.kind == 0) ? v.nl : v.at;
        for (int ln = 0; ln < v.nl; ln++) begin
            len = (v.kind == 1 && ln == v.at) ? ht - 1 : ht;
            w   = (v.kind == 2 && ln == v.at) ? hsy - 1 : hsy;
            for (int p = 0; p < len; p++) begin
                @(negedge Clock);
                if (v.kind == 3 && ln == v.at && p == 51) begin
                    check("rst_we", int'(a_we), 0);
                    check("rst_addr", int'(a_addr), 0);
                    check("rst_data", int'(a_data), 0);
                    check("rst_lock", int'(a_lock), 0);
                    check("rst_done", int'(a_done), 0);
                    check("rst_err", int'(a_err), 0);
                    check("rst_fcnt", int'(a_fc), 0);
                end
                Reset  = (v.kind == 3 && ln == v.at && p == 50);
                iHSync = (p < w) ? SA : ~SA;
                iVSync = (ln < vsy) ? SA : ~SA;
                col = p - (hsy + hbk);
                row = ln - (vsy + vbk);
                if (col >= 0 && col < hvis && row >= 0 && row < vvis) begin
                    pix = (v.pat == 0) ? 5
                        : (((col >> 5) ^ (row >> 4)) & 7);
                    if (v.wr != 0 && ln < cut &&
                        col % 32 == 16 && row % 16 == 8) begin
                        it.c    = cyc;
                        it.addr = ((row >> 4) << 5) | (col >> 5);
                        it.data = pix;
                        q.push_back(it);
                    end
                end else begin
                    pix = 0;
                end
                {iRed, iGreen, iBlue} = 3'(pix);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset  = 1'b1;
        iHSync = ~SA;
        iVSync = ~SA;
        {iRed, iGreen, iBlue} = 3'd0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        int ne, nd, nw;
        vec_t tv;

        vecs[0]  = '{0,  0, 37, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0,  0, 37, 0, 1, 0, 0, 6, 1, 0};
        vecs[2]  = '{0,  0, 37, 0, 1, 0, 1, 6, 1, 1};
        vecs[3]  = '{0,  0, 37, 1, 1, 0, 1, 6, 1, 2};
        vecs[4]  = '{1, 10, 37, 1, 1, 1, 1, 0, 0, 3};
        vecs[5]  = '{0,  0, 37, 1, 0, 0, 0, 0, 0, 3};
        vecs[6]  = '{0,  0, 37, 1, 1, 0, 0, 6, 1, 3};
        vecs[7]  = '{2, 10, 37, 1, 1, 1, 1, 0, 0, 4};
        vecs[8]  = '{0,  0, 37, 1, 0, 0, 0, 0, 0, 4};
        vecs[9]  = '{0,  0, 37, 1, 1, 0, 0, 6, 1, 4};
        vecs[10] = '{0,  0, 36, 1, 1, 0, 1, 6, 1, 5};
        vecs[11] = '{0,  0, 37, 1, 0, 1, 0, 0, 0, 5};
        vecs[12] = '{0,  0, 37, 1, 0, 0, 0, 0, 0, 5};
        vecs[13] = '{0,  0, 37, 1, 1, 0, 0, 6, 1, 5};
        vecs[14] = '{3, 20, 37, 1, 1, 0, 1, 3, 0, 0};
        vecs[15] = '{0,  0, 37, 1, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{0,  0, 37, 0, 1, 0, 0, 6, 1, 0};
        vecs[17] = '{0,  0, 37, 0, 1, 0, 1, 6, 1, 1};

        hvis = 96; hfr = 2; hsy = 4; hbk = 2;
        vvis = 32; vfr = 1; vsy = 2; vbk = 2;

        do_reset();
        check("reset_lock", int'(a_lock), 0);
        check("reset_we", int'(a_we), 0);
        check("reset_err", int'(a_err), 0);
        check("reset_fcnt", int'(a_fc), 0);

        mon_a = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ne = a_nerr;
            nd = a_ndone;
            nw = a_nwr;
            send_frame(vecs[i]);
            check($sformatf("v%0d_err", i), a_nerr - ne, vecs[i].e_err);
            check($sformatf("v%0d_done", i), a_ndone - nd, vecs[i].e_done);
            check($sformatf("v%0d_writes", i), a_nwr - nw, vecs[i].e_wr);
            check($sformatf("v%0d_lock", i), int'(a_lock), vecs[i].e_lock);
            check($sformatf("v%0d_fcnt", i), int'(a_fc), vecs[i].e_fc);
        end
        check("pending_writes", q.size(), 0);
        mon_a = 1'b0;

        hvis = 2; hfr = 1; hsy = 1; hbk = 1;
        vvis = 2; vfr = 1; vsy = 1; vbk = 1;
        do_reset();
        check("wrap_reset_fcnt", int'(b_fc), 0);
        ne = b_nerr;
        nd = b_ndone;
        nw = b_nwr;
        tv = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 0};
        for (int f = 0; f < 257; f++) send_frame(tv);
        check("wrap_fcnt_255", int'(b_fc), 255);
        check("wrap_done_255", b_ndone - nd, 255);
        check("wrap_err", b_nerr - ne, 0);
        check("wrap_lock", int'(b_lock), 1);
        check("wrap_writes", b_nwr - nw, 0);
        send_frame(tv);
        check("wrap_fcnt_0", int'(b_fc), 0);
        check("wrap_done_256", b_ndone - nd, 256);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
